// File: rtl/seg7_snake_pkg.sv
// Shared definitions for the 7-segment snake monitor: segment indices, FSM states,
// the segment adjacency table and small bit-counting helpers.
package seg7_snake_pkg;

  localparam int SEG_N = 7;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  // Entry i holds the segments that physically touch segment i (bit0=a .. bit6=g).
  localparam logic [6:0] ADJ_MASK [SEG_N] = '{
    7'b010_0010,  // a: b,f
    7'b100_0101,  // b: a,c,g
    7'b100_1010,  // c: b,d,g
    7'b001_0100,  // d: c,e
    7'b110_1000,  // e: d,f,g
    7'b101_0001,  // f: a,e,g
    7'b011_0110   // g: b,c,e,f
  };

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < SEG_N; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [6:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < SEG_N; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_snake_monitor_if.sv
// Display-bus and status bundle between the snake monitor and whoever drives/observes it.
interface seg7_snake_monitor_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       seg_in;
  logic             dp_in;
  logic             clr;
  logic [2:0]       head;
  logic             head_vld;
  logic             move_pulse;
  logic [CNT_W-1:0] move_cnt;
  logic [7:0]       err_cnt;
  logic [7:0]       dp_cnt;
  logic             fault;
  logic             stall;

  modport master (
    output seg_in, dp_in, clr,
    input  head, head_vld, move_pulse, move_cnt, err_cnt, dp_cnt, fault, stall
  );

  modport slave (
    input  seg_in, dp_in, clr,
    output head, head_vld, move_pulse, move_cnt, err_cnt, dp_cnt, fault, stall
  );
endinterface

// File: rtl/seg7_sync_filter.sv
// Two-flop synchronizer followed by a stability filter: the frame only loads a value
// that has been seen on STABLE_CYC consecutive synchronized samples.
module seg7_sync_filter #(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] raw,
  output logic [7:0] frame,
  output logic [7:0] frame_prev,
  output logic       f_change
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYC);

  logic [7:0]    sync1_reg, sync2_reg, cand_reg, frame_reg, prev_reg;
  logic [CW-1:0] run_reg, run_next;
  logic          change_reg, load;

  // run counts how many consecutive samples have matched the current candidate
  always_comb begin
    run_next = run_reg;
    if (sync2_reg != cand_reg) begin
      run_next = CW'(1);
    end else if (run_reg != RUN_MAX) begin
      run_next = run_reg + 1'b1;
    end
    load = (run_next == RUN_MAX) && (sync2_reg != frame_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      cand_reg   <= '0;
      run_reg    <= '0;
      frame_reg  <= '0;
      prev_reg   <= '0;
      change_reg <= 1'b0;
    end else begin
      sync1_reg  <= raw;
      sync2_reg  <= sync1_reg;
      cand_reg   <= sync2_reg;
      run_reg    <= run_next;
      change_reg <= load;
      if (load) begin
        prev_reg  <= frame_reg;
        frame_reg <= sync2_reg;
      end
    end
  end

  assign frame      = frame_reg;
  assign frame_prev = prev_reg;
  assign f_change   = change_reg;

endmodule

// File: rtl/seg7_snake_monitor.sv
// Receive-side checker for the 7-segment snake bus: classifies each filtered frame change.
// Optional stall watchdog is compiled in when SNAKE_MON_STALL_EN is defined.
module seg7_snake_monitor
  import seg7_snake_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 16,
  parameter int STALL_W    = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_snake_monitor_if.slave  bus
);
  logic [7:0] frame, frame_prev;
  logic       f_change;

  seg7_sync_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        ({bus.dp_in, bus.seg_in}),
    .frame      (frame),
    .frame_prev (frame_prev),
    .f_change   (f_change)
  );

  logic [6:0] cur, prev, on_mask, off_mask, adj_hit;
  logic [2:0] n_cur;
  logic       legal, dp_rise;

  assign cur      = frame[6:0];
  assign prev     = frame_prev[6:0];
  assign on_mask  = cur & ~prev;
  assign off_mask = prev & ~cur;
  assign n_cur    = popcount7(cur);
  assign dp_rise  = f_change & frame[7] & ~frame_prev[7];

  // A newly lit segment must touch something that was already lit
  generate
    for (genvar gi = 0; gi < SEG_N; gi++) begin : g_adj
      assign adj_hit[gi] = on_mask[gi] & (|(ADJ_MASK[gi] & prev));
    end
  endgenerate

  assign legal = ((n_cur == 3'd2) || (n_cur == 3'd3))
              && (popcount7(on_mask) <= 3'd1)
              && (popcount7(off_mask) <= 3'd1)
              && ((on_mask == '0) || (|adj_hit));

  mon_state_t       state_reg, state_next;
  logic [2:0]       head_reg, head_next;
  logic             head_vld_reg, head_vld_next;
  logic             pulse_reg, pulse_next;
  logic [CNT_W-1:0] move_cnt_reg, move_cnt_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;
  logic [7:0]       dp_cnt_reg, dp_cnt_next;

  always_comb begin
    state_next    = state_reg;
    head_next     = head_reg;
    head_vld_next = head_vld_reg;
    pulse_next    = 1'b0;
    move_cnt_next = move_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    dp_cnt_next   = dp_cnt_reg;
    if (bus.clr) begin
      state_next    = INIT;
      head_vld_next = 1'b0;
      move_cnt_next = '0;
      err_cnt_next  = '0;
      dp_cnt_next   = '0;
    end else begin
      if (dp_rise && (dp_cnt_reg != '1)) begin
        dp_cnt_next = dp_cnt_reg + 1'b1;
      end
      if (f_change) begin
        if (cur == '0) begin
          state_next    = INIT;
          head_vld_next = 1'b0;
        end else begin
          case (state_reg)
            INIT: begin
              if (n_cur == 3'd3) begin
                state_next = TRACK;
              end
            end
            TRACK: begin
              if (!legal) begin
                state_next    = FAULT;
                head_vld_next = 1'b0;
                if (err_cnt_reg != '1) begin
                  err_cnt_next = err_cnt_reg + 1'b1;
                end
              end else if (on_mask != '0) begin
                head_next     = onehot_to_idx(on_mask);
                head_vld_next = 1'b1;
                pulse_next    = 1'b1;
                if (move_cnt_reg != '1) begin
                  move_cnt_next = move_cnt_reg + 1'b1;
                end
              end
            end
            FAULT: begin
              state_next = FAULT;
            end
            default: begin
              state_next = INIT;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      head_reg     <= '0;
      head_vld_reg <= 1'b0;
      pulse_reg    <= 1'b0;
      move_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      dp_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      head_vld_reg <= head_vld_next;
      pulse_reg    <= pulse_next;
      move_cnt_reg <= move_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      dp_cnt_reg   <= dp_cnt_next;
    end
  end

`ifdef SNAKE_MON_STALL_EN
  logic [STALL_W-1:0] idle_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_reg <= '0;
    end else if (bus.clr || f_change) begin
      idle_reg <= '0;
    end else if ((state_reg == TRACK) && (idle_reg != '1)) begin
      idle_reg <= idle_reg + 1'b1;
    end
  end

  assign bus.stall = (state_reg == TRACK) && (idle_reg == '1);
`else
  // Watchdog absent: stall is constant 0 (STALL_W >= 1 makes this compare false).
  assign bus.stall = (STALL_W < 1);
`endif

  assign bus.head       = head_reg;
  assign bus.head_vld   = head_vld_reg;
  assign bus.move_pulse = pulse_reg;
  assign bus.move_cnt   = move_cnt_reg;
  assign bus.err_cnt    = err_cnt_reg;
  assign bus.dp_cnt     = dp_cnt_reg;
  assign bus.fault      = (state_reg == FAULT);

endmodule

// File: tb/tb_seg7_snake_monitor.sv
// Bench for seg7_snake_monitor: directed scenarios plus random frames, checked every cycle
// against a pin-history model. Define SNAKE_MON_STALL_EN to also exercise the stall watchdog.
`timescale 1ns/1ps
module tb_seg7_snake_monitor;
  localparam int S        = 4;
  localparam int CNT_W    = 4;
  localparam int STALL_W  = 4;
  localparam int MOVE_MAX = (1 << CNT_W) - 1;
  localparam int IDLE_MAX = (1 << STALL_W) - 1;
  localparam int M_INIT   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_FAULT  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_snake_monitor_if #(.CNT_W(CNT_W)) bus ();

  seg7_snake_monitor #(.STABLE_CYC(S), .CNT_W(CNT_W), .STALL_W(STALL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int pulses_seen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ea [10] = '{0, 0, 1, 1, 2, 2, 3, 4, 4, 5};
  int eb [10] = '{1, 5, 2, 6, 3, 6, 4, 5, 6, 6};

  function automatic bit adjacent(input int x, input int y);
    for (int i = 0; i < 10; i++) begin
      if ((ea[i] == x && eb[i] == y) || (ea[i] == y && eb[i] == x)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_legal(input logic [6:0] p, input logic [6:0] c);
    logic [6:0] on_s, off_s;
    int n;
    on_s  = c & ~p;
    off_s = p & ~c;
    n = $countones(c);
    if (n < 2 || n > 3) return 1'b0;
    if ($countones(on_s) > 1 || $countones(off_s) > 1) return 1'b0;
    if (on_s == 7'd0) return 1'b1;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (on_s[k] && p[j] && adjacent(k, j)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  logic [7:0] hist[$];       // pin samples, newest first
  logic [7:0] m_f, pend_prev, pend_cur;
  bit         pend;
  int         m_state, m_head, m_vld, m_pulse, m_move, m_err, m_dp, m_idle;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 2; i++) hist.push_back(8'h00);
    m_f = 8'h00; pend = 1'b0; pend_prev = 8'h00; pend_cur = 8'h00;
    m_state = M_INIT; m_head = 0; m_vld = 0; m_pulse = 0;
    m_move = 0; m_err = 0; m_dp = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] pin, input logic c);
    int old_state;
    logic [6:0] p7, c7, on_s;
    bit all_same;
    if (!r) begin
      model_reset();
      return;
    end
    old_state = m_state;
    m_pulse = 0;
    if (c) begin
      m_state = M_INIT; m_vld = 0; m_move = 0; m_err = 0; m_dp = 0;
    end else if (pend) begin
      p7 = pend_prev[6:0];
      c7 = pend_cur[6:0];
      if (pend_cur[7] && !pend_prev[7] && m_dp < 255) m_dp++;
      if (c7 == 7'd0) begin
        m_state = M_INIT; m_vld = 0;
      end else if (m_state == M_INIT) begin
        if ($countones(c7) == 3) m_state = M_TRACK;
      end else if (m_state == M_TRACK) begin
        if (!m_legal(p7, c7)) begin
          m_state = M_FAULT; m_vld = 0;
          if (m_err < 255) m_err++;
        end else begin
          on_s = c7 & ~p7;
          for (int k = 0; k < 7; k++) begin
            if (on_s[k]) begin
              m_head = k; m_vld = 1; m_pulse = 1;
              if (m_move < MOVE_MAX) m_move++;
            end
          end
        end
      end
    end
    // cycles spent in TRACK since the last frame change or clear
    if (c || pend) m_idle = 0;
    else if (old_state == M_TRACK && m_idle < IDLE_MAX) m_idle++;
    // frame accepted once the synchronized stream shows S equal samples
    hist.push_front(pin);
    void'(hist.pop_back());
    pend = 1'b0;
    all_same = 1'b1;
    for (int k = 2; k <= S + 1; k++) begin
      if (hist[k] != hist[2]) all_same = 1'b0;
    end
    if (all_same && hist[2] != m_f) begin
      pend = 1'b1; pend_prev = m_f; pend_cur = hist[2]; m_f = hist[2];
    end
  endtask

  initial begin : compare
    logic r_s, c_s;
    logic [7:0] pin_s;
    int exp_stall;
    model_reset();
    forever begin
      @(posedge clk);
      r_s = rst_n; c_s = bus.clr; pin_s = {bus.dp_in, bus.seg_in};
      model_step(r_s, pin_s, c_s);
      #1;
      if (bus.move_pulse) pulses_seen++;
`ifdef SNAKE_MON_STALL_EN
      exp_stall = (m_state == M_TRACK && m_idle == IDLE_MAX) ? 1 : 0;
`else
      exp_stall = 0;
`endif
      chk("head", int'(bus.head), m_head);
      chk("head_vld", int'(bus.head_vld), m_vld);
      chk("move_pulse", int'(bus.move_pulse), m_pulse);
      chk("move_cnt", int'(bus.move_cnt), m_move);
      chk("err_cnt", int'(bus.err_cnt), m_err);
      chk("dp_cnt", int'(bus.dp_cnt), m_dp);
      chk("fault", int'(bus.fault), (m_state == M_FAULT) ? 1 : 0);
      chk("stall", int'(bus.stall), exp_stall);
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] cur_seg = 7'h00;
  logic       cur_dp  = 1'b0;

  task automatic drive(input logic [6:0] seg, input logic dp, input int cycles);
    @(negedge clk);
    bus.seg_in = seg; bus.dp_in = dp;
    cur_seg = seg; cur_dp = dp;
    $display("drive seg=%02h dp=%0d hold=%0d", seg, dp, cycles);
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    $display("clr pulse");
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  function automatic logic [6:0] ring_frame(input int k);
    logic [6:0] f;
    f = 7'd0;
    f[k % 6] = 1'b1; f[(k + 1) % 6] = 1'b1; f[(k + 2) % 6] = 1'b1;
    return f;
  endfunction

  function automatic int pick_bit(input logic [6:0] m);
    int t;
    if (m == 7'd0) return -1;
    t = $urandom_range(0, $countones(m) - 1);
    for (int k = 0; k < 7; k++) begin
      if (m[k]) begin
        if (t == 0) return k;
        t--;
      end
    end
    return -1;
  endfunction

  function automatic logic [6:0] random_move(input logic [6:0] c);
    logic [6:0] nb, nx;
    int on_i, off_i, mode;
    nb = 7'd0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 7; j++) begin
        if (!c[k] && c[j] && adjacent(k, j)) nb[k] = 1'b1;
      end
    end
    on_i  = pick_bit(nb);
    off_i = pick_bit(c);
    mode  = $urandom_range(0, 5);
    nx = c;
    if (on_i >= 0 && mode != 0) nx[on_i] = 1'b1;
    if (off_i >= 0 && mode != 1) nx[off_i] = 1'b0;
    return nx;
  endfunction

  initial begin : stim
    int r;
    int hold;
    logic [6:0] nx;
    bus.seg_in = 7'h00; bus.dp_in = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset head_vld", int'(bus.head_vld), 0);
    chk("reset move_cnt", int'(bus.move_cnt), 0);
    chk("reset fault", int'(bus.fault), 0);
    rst_n = 1'b1;

    // enter TRACK then one legal move b on, e off
    drive(7'h31, 1'b0, 10);
    pulses_seen = 0;
    drive(7'h23, 1'b0, 10);
    chk("first move head", int'(bus.head), 1);
    chk("first move head_vld", int'(bus.head_vld), 1);
    chk("first move move_cnt", int'(bus.move_cnt), 1);
    chk("first move pulses", pulses_seen, 1);
    chk("first move err_cnt", int'(bus.err_cnt), 0);

    // move back, then a glitch one cycle too short to be accepted
    drive(7'h31, 1'b0, 10);
    pulses_seen = 0;
    drive(7'h35, 1'b0, S - 1);
    drive(7'h31, 1'b0, 12);
    chk("glitch pulses", pulses_seen, 0);
    chk("glitch move_cnt", int'(bus.move_cnt), 2);

    // d is not adjacent to a, b or f
    drive(7'h23, 1'b0, 10);
    drive(7'h29, 1'b0, 10);
    chk("fault flag", int'(bus.fault), 1);
    chk("fault err_cnt", int'(bus.err_cnt), 1);
    chk("fault head_vld", int'(bus.head_vld), 0);
    drive(7'h0C, 1'b0, 10);
    chk("sticky err_cnt", int'(bus.err_cnt), 1);
    pulse_clr();
    repeat (2) @(negedge clk);
    chk("clr fault", int'(bus.fault), 0);
    chk("clr err_cnt", int'(bus.err_cnt), 0);
    chk("clr move_cnt", int'(bus.move_cnt), 0);

    // 17 back-to-back legal moves around the outer ring, saturating a 4-bit counter
    drive(ring_frame(5), 1'b0, 10);
    pulses_seen = 0;
    for (int i = 1; i <= 17; i++) drive(ring_frame(5 + i), 1'b0, S);
    repeat (10) @(negedge clk);
    chk("ring move_cnt", int'(bus.move_cnt), 15);
    chk("ring pulses", pulses_seen, 17);

    // blank display, then three dp pulses
    drive(7'h00, 1'b0, 10);
    chk("blank head_vld", int'(bus.head_vld), 0);
    chk("blank err_cnt", int'(bus.err_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      drive(7'h00, 1'b1, 8);
      drive(7'h00, 1'b0, 8);
    end
    chk("dp_cnt", int'(bus.dp_cnt), 3);

    // asynchronous reset in the middle of tracking
    drive(7'h31, 1'b0, 10);
    drive(7'h23, 1'b0, 10);
    chk("pre-reset head_vld", int'(bus.head_vld), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset head_vld", int'(bus.head_vld), 0);
    chk("async reset move_cnt", int'(bus.move_cnt), 0);
    chk("async reset dp_cnt", int'(bus.dp_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

`ifdef SNAKE_MON_STALL_EN
    drive(7'h23, 1'b0, 10);
    drive(7'h31, 1'b0, 30);
    chk("stall set", int'(bus.stall), 1);
    drive(7'h23, 1'b0, 10);
    chk("stall cleared", int'(bus.stall), 0);
`endif

    // random frames: mostly snake-like moves, plus noise, blanks, dp toggles, glitches, clears
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 99);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S, S + 4);
      nx = cur_seg;
      if (r < 55) nx = random_move(cur_seg);
      else if (r < 68) nx = 7'($urandom_range(0, 127));
      else if (r < 75) nx = 7'h00;
      else if (r < 85) nx = ring_frame($urandom_range(0, 5));
      else if (r < 90) pulse_clr();
      if ($urandom_range(0, 3) == 0) drive(nx, ~cur_dp, hold);
      else drive(nx, cur_dp, hold);
    end
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_snake_monitor.md
# seg7_snake_monitor

Receive-side checker for the 7-segment snake display bus. It samples the eight segment lines (a–g plus dp) from the snake generator or from external pins, then synchronizes and glitch-filters them. It decodes each display change into a head-position update and checks every change against the segment adjacency rules. It reports moves, errors, dp pulses and an optional stall condition, for use as an on-chip self-check or in a loop-back test harness.

## Interface
Parameters:
- STABLE_CYC, 4, consecutive identical synchronized samples needed to accept a new frame (>=1)
- CNT_W, 16, width of move_cnt
- STALL_W, 26, width of stall watchdog counter

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- seg_in  in  7  segment lines, bit0=a … bit5=f, bit6=g; active high
- dp_in  in  1  decimal point line
- clr  in  1  synchronous clear of counters, fault and stall
- head  out  3  index of current snake head segment
- head_vld  out  1  head is valid
- move_pulse  out  1  one-cycle pulse per accepted move
- move_cnt  out  CNT_W  accepted moves, saturating
- err_cnt  out  8  illegal transitions, saturating
- dp_cnt  out  8  filtered dp rising edges, saturating
- fault  out  1  state == FAULT
- stall  out  1  watchdog expired (0 when the stall feature is compiled out)

Reset value of every output is 0.

## Operation
Front end: seg_in and dp_in pass through a 2-flop synchronizer. The 8-bit filtered frame F loads the synchronized value only after that value has held for STABLE_CYC consecutive samples. Shorter pulses are discarded.

On each change of F, with prev = old F[6:0] and cur = new F[6:0]:
- on = cur & ~prev, off = prev & ~cur, n = popcount(cur).
- Legal when all of the following hold:
  - n is 2 or 3
  - popcount(on) <= 1
  - popcount(off) <= 1
  - on == 0, or on is adjacent to at least one segment in prev

Adjacency: a–b,f; b–a,c,g; c–b,d,g; d–c,e; e–d,f,g; f–a,e,g; g–b,c,e,f.

State machine with states INIT, TRACK and FAULT:
- INIT (reset state): a frame with n==3 moves the block to TRACK. head_vld stays 0. Any other frame leaves it in INIT and counts no error.
- TRACK, legal change with on!=0: head <= index(on), head_vld <= 1, move_pulse for one cycle, move_cnt++.
- TRACK, legal change with on==0: no pulse; head is unchanged.
- TRACK, illegal change: err_cnt++, head_vld <= 0, go to FAULT.
- FAULT: sticky. Changes are ignored and err_cnt does not count further.
- cur == 0 (blank display) in any state: go to INIT, head_vld <= 0, no error.
- dp: each 0→1 transition of F[7] increments dp_cnt, in every state.
- clr: return to INIT and zero head_vld, move_cnt, err_cnt, dp_cnt and the stall counter.
  - clr overrides any same-cycle event.
  - The synchronizer and filter state are not cleared.
- All counters saturate at all-ones and never wrap.

## Timing
- Edge 1 is the first clk edge that samples a new pin value. F updates at edge 2+STABLE_CYC.
- head, head_vld, move_pulse, the counters and fault update at edge 3+STABLE_CYC.
- move_pulse is exactly one cycle wide. Back-to-back frame changes spaced STABLE_CYC cycles apart each produce a pulse.
- clr takes effect at the next edge.
- Reset asserted mid-operation: all outputs go to 0 immediately and the state returns to INIT.

## Configuration
- SNAKE_MON_STALL_EN defined:
  - An STALL_W-bit counter increments every cycle while in TRACK and resets on any F change or clr.
  - stall = counter saturated at 2^STALL_W-1 while in TRACK.
- SNAKE_MON_STALL_EN undefined: no counter is instantiated and stall is tied to 0.

## Structure
- Package seg7_snake_pkg:
  - segment index constants SEG_A…SEG_G
  - state enum (INIT, TRACK, FAULT)
  - 7-entry array of 7-bit adjacency masks
  - popcount and one-hot-to-index functions
- Sub-module seg7_sync_filter: the 2-flop synchronizer plus STABLE_CYC stability filter. It outputs F and a one-cycle f_change strobe. The monitor holds the classification FSM and the counters.

## Test plan
- Reset, then drive 0x31 (a,e,f) and then 0x23 (a,b,f). Expected: TRACK, head=1, head_vld=1, one move_pulse, move_cnt=1, err_cnt=0.
- From 0x31, toggle seg_in[2] high for STABLE_CYC-1 cycles. Expected: F unchanged, no pulse, counters unchanged.
- From TRACK at 0x23, drive 0x29 (a,d,f). Segment d is not adjacent to a, b or f. Expected: fault=1, err_cnt=1, head_vld=0. A further change to 0x0C leaves err_cnt=1. Pulsing clr returns to INIT with all counters 0.
- With CNT_W=4, drive 17 legal moves around the ring. Expected: move_cnt=15 and 17 move_pulses observed.
- Drive 0x00 while in TRACK. Expected: INIT, head_vld=0, err_cnt unchanged. Toggle dp_in 3 times with stable holds. Expected: dp_cnt=3.
- With SNAKE_MON_STALL_EN and STALL_W=4, enter TRACK and hold the frame. Expected: stall=1 once the counter reaches 15, and stall returns to 0 after the next legal move.
